// File: rtl/or1200_serial_div.sv
// or1200_serial_div: iterative restoring divider for l.div/l.divu (optional OR1200_DIV_EARLY_EXIT_EN shortcut when |a|<|b|)
module or1200_serial_div #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_freeze,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [width-1:0] operand_a,
  input  logic [width-1:0] operand_b,
  output logic [width-1:0] quotient,
  output logic [width-1:0] remainder,
  output logic             dbz,
  output logic             ov,
  output logic             done,
  output logic             div_stall
);
  localparam int cw = $clog2(width);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [width-2:0] rem;
  logic [width-1:0] dvd, dvs, mag_a, mag_b, rem_nx, dvd_nx;
  logic [width:0] partial;
  logic [cw-1:0] cnt;
  logic q_sign, r_sign, a_sign, b_sign, b_zero, early, last, start;
  // operand magnitudes, one restoring step, and the next-state decision
  always_comb begin
    a_sign = div_signed & operand_a[width-1];
    b_sign = div_signed & operand_b[width-1];
    mag_a = a_sign ? -operand_a : operand_a;
    mag_b = b_sign ? -operand_b : operand_b;
    b_zero = operand_b == '0;
`ifdef OR1200_DIV_EARLY_EXIT_EN
    early = mag_a < mag_b;
`else
    early = 1'b0;
`endif
    start = state == IDLE && div_start;
    partial = {1'b0, rem, dvd[width-1]} - {1'b0, dvs};
    rem_nx = partial[width] ? {rem, dvd[width-1]} : partial[width-1:0];
    dvd_nx = {dvd[width-2:0], ~partial[width]};
    last = cnt == '0;
    state_nx = state;
    if (start) state_nx = (b_zero || early) ? DONE : BUSY;
    else if (state == BUSY && last) state_nx = DONE;
    else if (state == DONE && !ex_freeze) state_nx = IDLE;
    done = state == DONE;
    div_stall = start || state == BUSY;
  end
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // datapath: latch magnitudes on start, shift one quotient bit per BUSY cycle, sign-fix on the last one
  always_ff @(posedge clk)
    if (rst) begin
      rem <= '0;
      dvd <= '0;
      dvs <= '0;
      cnt <= '0;
      q_sign <= 1'b0;
      r_sign <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      dbz <= 1'b0;
      ov <= 1'b0;
    end else if (start) begin
      rem <= '0;
      dvd <= mag_a;
      dvs <= mag_b;
      cnt <= cw'(width - 1);
      q_sign <= a_sign ^ b_sign;
      r_sign <= a_sign;
      dbz <= b_zero;
      ov <= div_signed && operand_a == {1'b1, {(width-1){1'b0}}} && &operand_b;
      if (b_zero || early) begin
        quotient <= '0;
        remainder <= operand_a;
      end
    end else if (state == BUSY) begin
      rem <= rem_nx[width-2:0];
      dvd <= dvd_nx;
      cnt <= cnt - 1'b1;
      if (last) begin
        quotient <= q_sign ? -dvd_nx : dvd_nx;
        remainder <= r_sign ? -rem_nx : rem_nx;
      end
    end
endmodule

// File: tb/tb_or1200_serial_div.sv
// tb_or1200_serial_div: randomized and directed checks of or1200_serial_div against an arithmetic reference model
module tb_or1200_serial_div;
  logic clk = 1'b0;
  logic rst, ex_freeze, div_start, div_signed;
  logic [31:0] operand_a, operand_b, quotient, remainder;
  logic dbz, ov, done, div_stall;
  int vecs = 0, errs = 0;
  logic [31:0] r_q, r_r;
  logic r_dbz, r_ov;
  int r_lat, r_stl;
  typedef struct {logic [31:0] a, b; logic s; logic [31:0] q, r; logic dz, o;} vec_t;
  vec_t tbl[8] = '{
    '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0},
    '{32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0},
    '{32'd100, 32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2, 1'b0, 1'b0},
    '{32'd5, 32'd0, 1'b0, 32'd0, 32'd5, 1'b1, 1'b0},
    '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, 1'b1},
    '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000, 1'b0, 1'b0},
    '{32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0},
    '{32'd3, 32'd10, 1'b0, 32'd0, 32'd3, 1'b0, 1'b0}
  };

  always #5 clk = ~clk;

  or1200_serial_div #(.width(32)) dut (
    .clk(clk), .rst(rst), .ex_freeze(ex_freeze), .div_start(div_start), .div_signed(div_signed),
    .operand_a(operand_a), .operand_b(operand_b), .quotient(quotient), .remainder(remainder),
    .dbz(dbz), .ov(ov), .done(done), .div_stall(div_stall)
  );

  function automatic void model(input logic [31:0] a, b, input logic s,
                                output logic [31:0] q, r, output logic dz, o, output int lat);
    longint sa, sb;
    logic [31:0] ma, mb;
    dz = b == 0;
    o = s && a == 32'h80000000 && b == 32'hFFFFFFFF;
    if (dz) begin
      q = 0;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    lat = 33;
    if (dz) lat = 1;
`ifdef OR1200_DIV_EARLY_EXIT_EN
    else if (ma < mb) lat = 1;
`endif
  endfunction

  task automatic do_div(input logic [31:0] a, b, input logic s);
    @(negedge clk);
    operand_a = a;
    operand_b = b;
    div_signed = s;
    div_start = 1'b1;
    ex_freeze = 1'b1;
    #1;
    r_lat = 0;
    r_stl = 0;
    do begin
      if (div_stall) r_stl++;
      @(posedge clk);
      r_lat++;
      #1;
      div_start = 1'b0;
      operand_a = $urandom;
      operand_b = $urandom;
      div_signed = 1'($urandom);
      @(negedge clk);
    end while (!done && r_lat < 100);
    r_q = quotient;
    r_r = remainder;
    r_dbz = dbz;
    r_ov = ov;
  endtask

  task automatic release_ex();
    ex_freeze = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex_freeze = 1'b0;
    div_start = 1'b1;
    div_signed = 1'b0;
    operand_a = 32'd100;
    operand_b = 32'd7;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    div_start = 1'b0;
    @(negedge clk);
    vecs++;
    if ({quotient, remainder, dbz, ov, done, div_stall} !== 68'd0) begin
      errs++;
      $display("FAIL reset_state got q=%h r=%h dbz=%b ov=%b done=%b stall=%b want all 0",
               quotient, remainder, dbz, ov, done, div_stall);
    end
  endtask

  task automatic test_directed();
    logic [31:0] q, r;
    logic dz, o;
    int lat;
    foreach (tbl[i]) begin
      model(tbl[i].a, tbl[i].b, tbl[i].s, q, r, dz, o, lat);
      do_div(tbl[i].a, tbl[i].b, tbl[i].s);
      vecs++;
      if ({r_q, r_r, r_dbz, r_ov} !== {tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].o}) begin
        errs++;
        $display("FAIL directed_%0d result got q=%h r=%h dbz=%b ov=%b want q=%h r=%h dbz=%b ov=%b",
                 i, r_q, r_r, r_dbz, r_ov, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].o);
      end
      vecs++;
      if (r_lat !== lat || r_stl !== lat) begin
        errs++;
        $display("FAIL directed_%0d timing got lat=%0d stall=%0d want %0d", i, r_lat, r_stl, lat);
      end
      release_ex();
      vecs++;
      if (done !== 1'b0) begin
        errs++;
        $display("FAIL directed_%0d release got done=%b want 0", i, done);
      end
    end
  endtask

  task automatic test_reset_busy();
    logic seen;
    @(negedge clk);
    operand_a = 32'd100;
    operand_b = 32'd7;
    div_signed = 1'b0;
    div_start = 1'b1;
    ex_freeze = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    vecs++;
    if ({quotient, remainder, dbz, ov, done, div_stall} !== 68'd0) begin
      errs++;
      $display("FAIL reset_busy got q=%h r=%h dbz=%b ov=%b done=%b stall=%b want all 0",
               quotient, remainder, dbz, ov, done, div_stall);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= done | div_stall;
    end
    vecs++;
    if (seen !== 1'b0) begin
      errs++;
      $display("FAIL reset_abandon got done_or_stall=%b want 0", seen);
    end
    do_div(32'd100, 32'd7, 1'b0);
    vecs++;
    if ({r_q, r_r, r_dbz, r_ov, r_lat} !== {32'd14, 32'd2, 1'b0, 1'b0, 32'd33}) begin
      errs++;
      $display("FAIL reset_rerun got q=%h r=%h dbz=%b ov=%b lat=%0d want q=e r=2 dbz=0 ov=0 lat=33",
               r_q, r_r, r_dbz, r_ov, r_lat);
    end
    release_ex();
  endtask

  task automatic test_freeze();
    logic [31:0] q, r;
    logic dz, o;
    int lat;
    do_div(32'd100, 32'd7, 1'b0);
    div_start = 1'b1;
    repeat (5) begin
      operand_a = $urandom;
      operand_b = $urandom;
      @(negedge clk);
      vecs++;
      if ({done, quotient, remainder, dbz, ov, div_stall} !== {1'b1, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0}) begin
        errs++;
        $display("FAIL freeze_hold got done=%b q=%h r=%h dbz=%b ov=%b stall=%b want done=1 q=e r=2 stall=0",
                 done, quotient, remainder, dbz, ov, div_stall);
      end
    end
    div_start = 1'b0;
    release_ex();
    vecs++;
    if ({done, div_stall} !== 2'b00) begin
      errs++;
      $display("FAIL freeze_release got done=%b stall=%b want 0 0", done, div_stall);
    end
    model(32'd3, 32'd10, 1'b0, q, r, dz, o, lat);
    do_div(32'd3, 32'd10, 1'b0);
    vecs++;
    if ({r_q, r_r, r_lat, r_stl} !== {32'd0, 32'd3, lat, lat}) begin
      errs++;
      $display("FAIL freeze_next got q=%h r=%h lat=%0d stall=%0d want q=0 r=3 lat=%0d", r_q, r_r, r_lat, r_stl, lat);
    end
    release_ex();
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r;
    logic s, dz, o;
    int lat;
    for (int n = 0; n < 50; n++) begin
      s = 1'($urandom);
      a = $urandom >> $urandom_range(0, 31);
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1)) a = -a;
      if ($urandom_range(0, 1)) b = -b;
      case ($urandom_range(0, 9))
        0: b = 0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = $urandom_range(0, 50); b = 32'd51 + $urandom_range(0, 1000); end
        default: ;
      endcase
      model(a, b, s, q, r, dz, o, lat);
      do_div(a, b, s);
      vecs++;
      if ({r_q, r_r, r_dbz, r_ov} !== {q, r, dz, o}) begin
        errs++;
        $display("FAIL random_%0d a=%h b=%h s=%b got q=%h r=%h dbz=%b ov=%b want q=%h r=%h dbz=%b ov=%b",
                 n, a, b, s, r_q, r_r, r_dbz, r_ov, q, r, dz, o);
      end
      vecs++;
      if (r_lat !== lat || r_stl !== lat) begin
        errs++;
        $display("FAIL random_%0d timing got lat=%0d stall=%0d want %0d", n, r_lat, r_stl, lat);
      end
      release_ex();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, q, r;
    logic dz, o;
    int lat;
    for (int n = 0; n < 4; n++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(8, 30);
      model(a, b, 1'b1, q, r, dz, o, lat);
      do_div(a, b, 1'b1);
      vecs++;
      if ({r_q, r_r, r_dbz, r_ov, r_lat} !== {q, r, dz, o, lat}) begin
        errs++;
        $display("FAIL back_to_back_%0d got q=%h r=%h dbz=%b ov=%b lat=%0d want q=%h r=%h dbz=%b ov=%b lat=%0d",
                 n, r_q, r_r, r_dbz, r_ov, r_lat, q, r, dz, o, lat);
      end
      release_ex();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_busy();
    test_freeze();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/or1200_serial_div.md
Name: or1200_serial_div

Overview:
- Iterative restoring divider in the EX stage, directly downstream of the operand mux stage.
- Consumes the registered operand_a/operand_b on l.div/l.divu.
- Raises a stall request to freeze the pipeline while iterating, then holds quotient/remainder until the EX stage advances.
- Result is muxed into the ALU result path by the EX result selector.

Parameters:
width, 32, operand/result width in bits (must be even, >=4)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
ex_freeze  input  1  EX stage frozen; DONE held while high
div_start  input  1  divide instruction present in EX with valid operands
div_signed  input  1  1 = l.div (two's complement), 0 = l.divu; sampled with div_start
operand_a  input  width  dividend
operand_b  input  width  divisor
quotient  output  width  quotient, valid while done=1
remainder  output  width  remainder, valid while done=1
dbz  output  1  divide-by-zero flag, valid while done=1
ov  output  1  signed overflow flag (MIN/-1), valid while done=1
done  output  1  result valid
div_stall  output  1  stall request to freeze logic

Behaviour:
- Reset: state=IDLE; quotient, remainder, counter and internal regs = 0; dbz=ov=done=0. Reset wins over any other event, including mid-BUSY; the operation is abandoned and no done pulse follows.
- States: IDLE, BUSY, DONE.
- IDLE -> BUSY on edge with div_start=1.
  - Latch |a|, |b|, quotient sign = a_sign^b_sign and remainder sign = a_sign (signs forced 0 when div_signed=0).
  - Set counter=width-1.
  - Flags: dbz = (operand_b==0); ov = div_signed & (a==MIN) & (b==all ones).
- IDLE -> DONE directly if operand_b==0 (1-cycle dbz path): quotient=0, remainder=operand_a.
- BUSY iterations, one quotient bit per cycle, MSB first:
  - partial = {rem[width-2:0], dividend_msb} - divisor.
  - If non-negative: keep partial and shift in 1; otherwise restore and shift in 0.
  - Counter decrements; BUSY -> DONE on the edge where counter==0.
  - On that edge apply sign fix-up: negate quotient if q_sign, negate remainder if r_sign.
- BUSY is not gated by ex_freeze; ex_freeze is expected high because of div_stall.
- DONE:
  - done=1; outputs stable.
  - DONE -> IDLE on edge with ex_freeze=0 (instruction leaves EX).
  - While ex_freeze=1 stay in DONE, ignore div_start and never restart.
- div_stall = (IDLE & div_start) | BUSY; combinational; 0 in DONE.
- Latency, normal path: start edge T0, BUSY for width cycles, done=1 from cycle T0+width+1. div_stall is high for width+1 cycles.
- Overflow (MIN/-1): quotient=MIN (wraps), remainder=0, ov=1.
- Unsigned: ov always 0.
- Operand changes after the start edge are ignored.
- Back-to-back divides: the next div_start is accepted in the IDLE cycle following DONE.

Optional Feature:
OR1200_DIV_EARLY_EXIT_EN
- Defined: in the IDLE->start decision, if |a| < |b| (magnitude, unsigned compare) and b != 0, go directly to DONE with quotient=0 and remainder=operand_a. This takes 1 cycle and div_stall is high for 1 cycle.
- Undefined: such cases take the full width-iteration path with identical results.
- Result values are identical either way; only latency differs.

Test Plan:
- Unsigned 100/7, div_signed=0, width=32 -> quotient=14, remainder=2, dbz=0, ov=0; done first high 33 cycles after the start edge; div_stall high for exactly 33 cycles.
- Signed -100/7 (0xFFFFFF9C/0x7) -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Signed 100/-7 -> quotient=0xFFFFFFF2, remainder=2.
- 5/0 unsigned -> next cycle done=1, dbz=1, quotient=0, remainder=5; div_stall high for 1 cycle.
- Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, ov=1, dbz=0.
- Assert rst at cycle 10 of BUSY -> next cycle state IDLE, all outputs 0, div_stall=0; a new 100/7 afterwards completes normally.
- Hold ex_freeze=1 for 5 cycles after done with div_start=1 -> done and outputs stay constant, no restart. Drop ex_freeze -> IDLE. A 3/10 then gives quotient=0, remainder=3: done after 1 cycle with OR1200_DIV_EARLY_EXIT_EN, after 33 cycles without.
